// File: rtl/load_store_queue_pkg.sv
// Shared definitions for the load/store queue: RV32I memory funct3 codes,
// the IO address boundary and the request FSM states.
package load_store_queue_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [31:0] LSQ_IO_BASE = 32'h0003_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DRAIN = 2'd2
    } lsq_state_e;

endpackage

// File: rtl/load_store_queue_load_extend.sv
// Load result extension: turns LSB-aligned raw memory data into the
// architectural 32-bit value according to the load's funct3.
module ls_load_extend
    import load_store_queue_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] raw,
    output logic [31:0] value
);

    always_comb begin
        value = raw;
        case (funct3)
            F3_LB:   value = {{24{raw[7]}}, raw[7:0]};
            F3_LH:   value = {{16{raw[15]}}, raw[15:0]};
            F3_LBU:  value = {24'd0, raw[7:0]};
            F3_LHU:  value = {16'd0, raw[15:0]};
            default: value = raw;
        endcase
    end

endmodule

// File: rtl/load_store_queue.sv
// Program-ordered load/store queue: allocates at dispatch, fills from the LS
// reservation station, executes the head against memory and reports on the LS CDB.
module load_store_queue
    import load_store_queue_pkg::*;
#(
    parameter int unsigned LSQ_DEPTH_LOG = 3,
    parameter int unsigned ROB_ID_W      = 5,
    parameter logic [31:0] IO_BASE       = LSQ_IO_BASE
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    input  logic                _clear,
    input  logic                _ls_ready,
    input  logic                _ls_is_store,
    input  logic [2:0]          _ls_funct3,
    input  logic [ROB_ID_W-1:0] _ls_rob_id,
    output logic                _lsq_full,
    input  logic                _lsb_rs_ready,
    input  logic [ROB_ID_W-1:0] _lsb_rob_id,
    input  logic [31:0]         _lsb_st_value,
    input  logic [31:0]         _lsb_ptr_value,
    input  logic                _rob_head_valid,
    input  logic [ROB_ID_W-1:0] _rob_head_id,
    output logic                _mem_req,
    output logic                _mem_we,
    output logic [31:0]         _mem_addr,
    output logic [1:0]          _mem_len,
    output logic [31:0]         _mem_wdata,
    input  logic                _mem_done,
    input  logic [31:0]         _mem_rdata,
    output logic                _cdb_ls_ready,
    output logic [ROB_ID_W-1:0] _cdb_ls_rob_id,
    output logic [31:0]         _cdb_ls_value
);

    localparam int unsigned DEPTH = 1 << LSQ_DEPTH_LOG;
    localparam int unsigned PW    = LSQ_DEPTH_LOG;
    localparam int unsigned CW    = LSQ_DEPTH_LOG + 1;

    logic [DEPTH-1:0]    ent_valid;
    logic [DEPTH-1:0]    ent_is_store;
    logic [DEPTH-1:0]    ent_addr_valid;
    logic [2:0]          ent_funct3 [DEPTH];
    logic [ROB_ID_W-1:0] ent_rob_id [DEPTH];
    logic [31:0]         ent_addr   [DEPTH];
    logic [31:0]         ent_data   [DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    lsq_state_e    state;

    logic        head_eligible;
    logic        do_pop;
    logic [31:0] load_value;

    ls_load_extend u_extend (
        .funct3 (ent_funct3[head]),
        .raw    (_mem_rdata),
        .value  (load_value)
    );

    // Non-IO loads may run speculatively; IO loads and all stores wait for ROB head.
    always_comb begin
        head_eligible = 1'b0;
        if (ent_valid[head] && ent_addr_valid[head]) begin
            if (!ent_is_store[head] && (ent_addr[head] < IO_BASE)) begin
                head_eligible = 1'b1;
            end else if (_rob_head_valid && (_rob_head_id == ent_rob_id[head])) begin
                head_eligible = 1'b1;
            end
        end
    end

    assign do_pop    = (state == ST_BUSY) && _mem_done;
    assign _lsq_full = (count >= CW'(DEPTH - 1));

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            ent_valid      <= '0;
            ent_is_store   <= '0;
            ent_addr_valid <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_funct3[PW'(i)] <= '0;
                ent_rob_id[PW'(i)] <= '0;
                ent_addr[PW'(i)]   <= '0;
                ent_data[PW'(i)]   <= '0;
            end
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            state          <= ST_IDLE;
            _mem_req       <= 1'b0;
            _mem_we        <= 1'b0;
            _mem_addr      <= '0;
            _mem_len       <= '0;
            _mem_wdata     <= '0;
            _cdb_ls_ready  <= 1'b0;
            _cdb_ls_rob_id <= '0;
            _cdb_ls_value  <= '0;
        end else if (rdy_in) begin
            _cdb_ls_ready <= 1'b0;
            if (_clear) begin
                // An outstanding request (load or committed store) must still see
                // its done pulse; DRAIN keeps the request up and swallows the result.
                ent_valid      <= '0;
                ent_addr_valid <= '0;
                head           <= '0;
                tail           <= '0;
                count          <= '0;
                if ((state != ST_IDLE) && !_mem_done) begin
                    state <= ST_DRAIN;
                end else begin
                    state    <= ST_IDLE;
                    _mem_req <= 1'b0;
                end
            end else begin
                if (_ls_ready) begin
                    ent_valid[tail]      <= 1'b1;
                    ent_is_store[tail]   <= _ls_is_store;
                    ent_addr_valid[tail] <= 1'b0;
                    ent_funct3[tail]     <= _ls_funct3;
                    ent_rob_id[tail]     <= _ls_rob_id;
                    tail                 <= tail + PW'(1);
                end
                if (_lsb_rs_ready) begin
                    for (int unsigned i = 0; i < DEPTH; i++) begin
                        if (ent_valid[PW'(i)] && (ent_rob_id[PW'(i)] == _lsb_rob_id)) begin
                            ent_addr_valid[PW'(i)] <= 1'b1;
                            ent_addr[PW'(i)]       <= _lsb_ptr_value;
                            ent_data[PW'(i)]       <= _lsb_st_value;
                        end
                    end
                end
                count <= count + CW'(_ls_ready) - CW'(do_pop);

                case (state)
                    ST_IDLE: begin
                        if (head_eligible) begin
                            state      <= ST_BUSY;
                            _mem_req   <= 1'b1;
                            _mem_we    <= ent_is_store[head];
                            _mem_addr  <= ent_addr[head];
                            _mem_len   <= ent_funct3[head][1:0];
                            _mem_wdata <= ent_is_store[head] ? ent_data[head] : '0;
                        end
                    end
                    ST_BUSY: begin
                        if (_mem_done) begin
                            state                <= ST_IDLE;
                            _mem_req             <= 1'b0;
                            _cdb_ls_ready        <= 1'b1;
                            _cdb_ls_rob_id       <= ent_rob_id[head];
                            _cdb_ls_value        <= ent_is_store[head] ? '0 : load_value;
                            ent_valid[head]      <= 1'b0;
                            ent_addr_valid[head] <= 1'b0;
                            head                 <= head + PW'(1);
                        end
                    end
                    ST_DRAIN: begin
                        if (_mem_done) begin
                            state    <= ST_IDLE;
                            _mem_req <= 1'b0;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    dispatch_into_full: assert property (@(posedge clk_in) disable iff (rst_in)
        !(rdy_in && !_clear && _ls_ready && (count == CW'(DEPTH))));

endmodule

// File: tb/tb_load_store_queue.sv
// Directed bench for load_store_queue with a transaction-level queue model
// checked every cycle, plus literal expectations for the key scenarios.
module tb_load_store_queue;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        _clear;
    logic        _ls_ready;
    logic        _ls_is_store;
    logic [2:0]  _ls_funct3;
    logic [4:0]  _ls_rob_id;
    logic        _lsq_full;
    logic        _lsb_rs_ready;
    logic [4:0]  _lsb_rob_id;
    logic [31:0] _lsb_st_value;
    logic [31:0] _lsb_ptr_value;
    logic        _rob_head_valid;
    logic [4:0]  _rob_head_id;
    logic        _mem_req;
    logic        _mem_we;
    logic [31:0] _mem_addr;
    logic [1:0]  _mem_len;
    logic [31:0] _mem_wdata;
    logic        _mem_done;
    logic [31:0] _mem_rdata;
    logic        _cdb_ls_ready;
    logic [4:0]  _cdb_ls_rob_id;
    logic [31:0] _cdb_ls_value;

    always #5 clk_in = ~clk_in;

    load_store_queue #(.LSQ_DEPTH_LOG(3), .ROB_ID_W(5), .IO_BASE(32'h0003_0000)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), ._clear(_clear),
        ._ls_ready(_ls_ready), ._ls_is_store(_ls_is_store), ._ls_funct3(_ls_funct3),
        ._ls_rob_id(_ls_rob_id), ._lsq_full(_lsq_full),
        ._lsb_rs_ready(_lsb_rs_ready), ._lsb_rob_id(_lsb_rob_id),
        ._lsb_st_value(_lsb_st_value), ._lsb_ptr_value(_lsb_ptr_value),
        ._rob_head_valid(_rob_head_valid), ._rob_head_id(_rob_head_id),
        ._mem_req(_mem_req), ._mem_we(_mem_we), ._mem_addr(_mem_addr),
        ._mem_len(_mem_len), ._mem_wdata(_mem_wdata), ._mem_done(_mem_done),
        ._mem_rdata(_mem_rdata), ._cdb_ls_ready(_cdb_ls_ready),
        ._cdb_ls_rob_id(_cdb_ls_rob_id), ._cdb_ls_value(_cdb_ls_value)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    typedef struct {
        bit          st;
        logic [2:0]  f3;
        logic [4:0]  rob;
        bit          av;
        logic [31:0] addr;
        logic [31:0] data;
    } op_t;

    op_t         q[$];
    bit          busy, orphan;
    logic        e_req, e_we, e_cdb;
    logic [31:0] e_addr, e_wdata, e_cdb_val;
    logic [1:0]  e_len;
    logic [4:0]  e_cdb_rob;

    function automatic logic [31:0] ext(input logic [2:0] f3, input logic [31:0] raw);
        int unsigned b = raw % 256;
        int unsigned h = raw % 65536;
        case (f3)
            3'b000:  return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'b001:  return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'b100:  return b;
            3'b101:  return h;
            default: return raw;
        endcase
    endfunction

    function automatic bit may_issue(input op_t o);
        if (!o.av) return 1'b0;
        if (!o.st && o.addr < 32'h0003_0000) return 1'b1;
        return _rob_head_valid && (_rob_head_id == o.rob);
    endfunction

    always @(posedge clk_in or posedge rst_in) begin
        op_t o;
        if (rst_in) begin
            q.delete();
            busy = 0; orphan = 0;
            e_req = 0; e_we = 0; e_addr = 0; e_len = 0; e_wdata = 0;
            e_cdb = 0; e_cdb_rob = 0; e_cdb_val = 0;
        end else if (rdy_in) begin
            e_cdb = 0;
            if (_clear) begin
                q.delete();
                if ((busy || orphan) && !_mem_done) orphan = 1;
                else begin orphan = 0; e_req = 0; end
                busy = 0;
            end else begin
                if (busy) begin
                    if (_mem_done) begin
                        o = q.pop_front();
                        busy = 0; e_req = 0; e_cdb = 1;
                        e_cdb_rob = o.rob;
                        e_cdb_val = o.st ? 32'd0 : ext(o.f3, _mem_rdata);
                    end
                end else if (orphan) begin
                    if (_mem_done) begin orphan = 0; e_req = 0; end
                end else if (q.size() > 0 && may_issue(q[0])) begin
                    busy = 1; e_req = 1; e_we = q[0].st; e_addr = q[0].addr;
                    e_len = q[0].f3[1:0]; e_wdata = q[0].st ? q[0].data : 32'd0;
                end
                if (_lsb_rs_ready)
                    foreach (q[i])
                        if (q[i].rob == _lsb_rob_id) begin
                            q[i].av = 1; q[i].addr = _lsb_ptr_value; q[i].data = _lsb_st_value;
                        end
                if (_ls_ready) begin
                    o.st = _ls_is_store; o.f3 = _ls_funct3; o.rob = _ls_rob_id;
                    o.av = 0; o.addr = 0; o.data = 0;
                    q.push_back(o);
                end
            end
        end
    end

    always @(negedge clk_in) begin
        if (!rst_in) begin
            chk("full", 32'(_lsq_full), 32'(q.size() >= 7));
            chk("req", 32'(_mem_req), 32'(e_req));
            if (e_req) begin
                chk("we", 32'(_mem_we), 32'(e_we));
                chk("addr", _mem_addr, e_addr);
                chk("len", 32'(_mem_len), 32'(e_len));
                if (e_we) chk("wdata", _mem_wdata, e_wdata);
            end
            chk("cdb", 32'(_cdb_ls_ready), 32'(e_cdb));
            if (e_cdb) begin
                chk("cdb_rob", 32'(_cdb_ls_rob_id), 32'(e_cdb_rob));
                chk("cdb_val", _cdb_ls_value, e_cdb_val);
            end
        end
    end

    // ---------------- memory responder ----------------
    int          mem_lat = 1;
    bit          mem_hold = 0;
    logic [31:0] resp_data = 0;
    int          req_age;

    initial begin
        _mem_done = 0; _mem_rdata = 0; req_age = 0;
        forever begin
            @(negedge clk_in);
            if (_mem_done) begin
                _mem_done = 0; req_age = 0;
            end else if (_mem_req && !rst_in && !mem_hold) begin
                req_age++;
                if (req_age >= mem_lat) begin _mem_done = 1; _mem_rdata = resp_data; end
            end else if (!_mem_req) begin
                req_age = 0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic dispatch(input bit st, input logic [2:0] f3, input logic [4:0] rob);
        _ls_ready = 1; _ls_is_store = st; _ls_funct3 = f3; _ls_rob_id = rob;
        @(negedge clk_in);
        _ls_ready = 0;
    endtask

    task automatic fill(input logic [4:0] rob, input logic [31:0] addr, input logic [31:0] data);
        _lsb_rs_ready = 1; _lsb_rob_id = rob; _lsb_ptr_value = addr; _lsb_st_value = data;
        @(negedge clk_in);
        _lsb_rs_ready = 0;
    endtask

    task automatic wait_req(input logic we, input logic [31:0] addr, input logic [1:0] len,
                            input logic [31:0] wdata);
        bit found = 0;
        repeat (30) begin
            @(negedge clk_in);
            if (_mem_req) begin found = 1; break; end
        end
        chk("req_seen", 32'(found), 32'd1);
        if (found) begin
            chk("req_we_lit", 32'(_mem_we), 32'(we));
            chk("req_addr_lit", _mem_addr, addr);
            chk("req_len_lit", 32'(_mem_len), 32'(len));
            if (we) chk("req_wdata_lit", _mem_wdata, wdata);
        end
    endtask

    task automatic wait_cdb(input logic [4:0] rob, input logic [31:0] val);
        bit found = 0;
        repeat (30) begin
            @(negedge clk_in);
            if (_cdb_ls_ready) begin found = 1; break; end
        end
        chk("cdb_seen", 32'(found), 32'd1);
        if (found) begin
            chk("cdb_rob_lit", 32'(_cdb_ls_rob_id), 32'(rob));
            chk("cdb_val_lit", _cdb_ls_value, val);
        end
    endtask

    task automatic no_req(input int n);
        int hits = 0;
        repeat (n) begin
            @(negedge clk_in);
            if (_mem_req) hits++;
        end
        chk("no_req", hits, 0);
    endtask

    task automatic no_cdb(input int n);
        int hits = 0;
        repeat (n) begin
            @(negedge clk_in);
            if (_cdb_ls_ready) hits++;
        end
        chk("no_cdb", hits, 0);
    endtask

    task automatic load_op(input logic [2:0] f3, input logic [4:0] rob, input logic [31:0] addr,
                           input logic [31:0] raw, input logic [31:0] exp_val);
        resp_data = raw;
        dispatch(0, f3, rob);
        fill(rob, addr, 32'd0);
        wait_req(0, addr, f3[1:0], 32'd0);
        wait_cdb(rob, exp_val);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in = 1; rdy_in = 1; _clear = 0;
        _ls_ready = 0; _ls_is_store = 0; _ls_funct3 = 0; _ls_rob_id = 0;
        _lsb_rs_ready = 0; _lsb_rob_id = 0; _lsb_st_value = 0; _lsb_ptr_value = 0;
        _rob_head_valid = 0; _rob_head_id = 0;
        repeat (2) @(negedge clk_in);
        chk("rst_req", 32'(_mem_req), 0);
        chk("rst_full", 32'(_lsq_full), 0);
        chk("rst_cdb", 32'(_cdb_ls_ready), 0);
        chk("rst_addr", _mem_addr, 0);
        rst_in = 0;
        @(negedge clk_in);

        // 1: plain word load
        load_op(3'b010, 5'd3, 32'h100, 32'hDEADBEEF, 32'hDEADBEEF);
        // 2: extension
        load_op(3'b000, 5'd8, 32'h104, 32'h0000_0080, 32'hFFFF_FF80);
        load_op(3'b100, 5'd9, 32'h105, 32'h0000_0080, 32'h0000_0080);
        load_op(3'b001, 5'd10, 32'h106, 32'h0000_8001, 32'hFFFF_8001);

        // 3: store waits for ROB head
        _rob_head_valid = 1; _rob_head_id = 5'd4;
        dispatch(1, 3'b010, 5'd5);
        fill(5'd5, 32'h200, 32'h1234_5678);
        no_req(5);
        _rob_head_id = 5'd5;
        wait_req(1, 32'h200, 2'd2, 32'h1234_5678);
        wait_cdb(5'd5, 32'd0);

        // 4: IO load held, younger load blocked in order
        _rob_head_id = 5'd6;
        dispatch(0, 3'b010, 5'd7);
        dispatch(0, 3'b010, 5'd8);
        fill(5'd7, 32'h0003_0004, 32'd0);
        fill(5'd8, 32'h300, 32'd0);
        no_req(5);
        resp_data = 32'h0000_00AA;
        _rob_head_id = 5'd7;
        wait_req(0, 32'h0003_0004, 2'd2, 32'd0);
        wait_cdb(5'd7, 32'h0000_00AA);
        resp_data = 32'h0000_0BBB;
        wait_req(0, 32'h300, 2'd2, 32'd0);
        wait_cdb(5'd8, 32'h0000_0BBB);

        // 5: full flag, dispatch+pop in the same cycle, pointer wrap
        for (int i = 0; i < 7; i++) begin
            dispatch(0, 3'b010, 5'(20 + i));
            if (i == 5) chk("full_at_6", 32'(_lsq_full), 0);
        end
        chk("full_at_7", 32'(_lsq_full), 1);
        mem_lat = 2;
        resp_data = 32'h0000_0800;
        fill(5'd20, 32'h800, 32'd0);
        wait_req(0, 32'h800, 2'd2, 32'd0);
        @(negedge clk_in);
        dispatch(0, 3'b010, 5'd27);
        chk("full_after_swap", 32'(_lsq_full), 1);
        mem_lat = 1;
        for (int i = 21; i <= 27; i++) begin
            resp_data = 32'(i * 16);
            fill(5'(i), 32'(32'h900 + i * 4), 32'd0);
        end
        repeat (60) begin
            if (q.size() == 0 && !_mem_req && !e_cdb) break;
            @(negedge clk_in);
        end
        chk("drained", q.size(), 0);
        chk("full_empty", 32'(_lsq_full), 0);

        // rdy_in low freezes state: a fill presented then is lost
        dispatch(0, 3'b010, 5'd14);
        rdy_in = 0;
        fill(5'd14, 32'h140, 32'd0);
        no_req(3);
        rdy_in = 1;
        no_req(3);
        resp_data = 32'h0000_0014;
        fill(5'd14, 32'h140, 32'd0);
        wait_req(0, 32'h140, 2'd2, 32'd0);
        wait_cdb(5'd14, 32'h0000_0014);

        // 6a: clear during in-flight load
        mem_lat = 4;
        resp_data = 32'h5555_5555;
        dispatch(0, 3'b010, 5'd1);
        dispatch(0, 3'b010, 5'd2);
        fill(5'd1, 32'h500, 32'd0);
        wait_req(0, 32'h500, 2'd2, 32'd0);
        _clear = 1;
        @(negedge clk_in);
        _clear = 0;
        chk("drain_req_held", 32'(_mem_req), 1);
        no_cdb(8);
        chk("drain_req_low", 32'(_mem_req), 0);
        chk("drain_empty", 32'(_lsq_full), 0);

        // 6b: clear during in-flight store
        _rob_head_id = 5'd30;
        dispatch(1, 3'b010, 5'd30);
        dispatch(0, 3'b010, 5'd31);
        fill(5'd30, 32'h600, 32'hCAFE_F00D);
        fill(5'd31, 32'h700, 32'd0);
        wait_req(1, 32'h600, 2'd2, 32'hCAFE_F00D);
        _clear = 1;
        @(negedge clk_in);
        _clear = 0;
        chk("store_req_held", 32'(_mem_req), 1);
        no_cdb(8);
        no_req(4);

        // 6c: async reset mid-request
        mem_lat = 1;
        mem_hold = 1;
        dispatch(0, 3'b010, 5'd12);
        fill(5'd12, 32'h120, 32'd0);
        wait_req(0, 32'h120, 2'd2, 32'd0);
        #2 rst_in = 1;
        #1;
        chk("arst_req", 32'(_mem_req), 0);
        chk("arst_addr", _mem_addr, 0);
        chk("arst_len", 32'(_mem_len), 0);
        chk("arst_cdb", 32'(_cdb_ls_ready), 0);
        chk("arst_full", 32'(_lsq_full), 0);
        @(negedge clk_in);
        rst_in = 0;
        mem_hold = 0;
        no_req(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
